// File: rtl/synth_voice_pkg.sv
// Shared voice-allocator types and default sizes.
package synth_voice_pkg;

    typedef enum logic [1:0] {
        V_IDLE    = 2'd0,
        V_ACTIVE  = 2'd1,
        V_RELEASE = 2'd2
    } voice_state_t;

    localparam int RELEASE_W      = 16;
    localparam int NUM_VOICES_DEF = 2;
    localparam int NUM_KEYS_DEF   = 4;

endpackage

// File: rtl/voice_allocator_slot.sv
// One voice: IDLE/ACTIVE/RELEASE FSM, release tail counter, saturating age and key register.
module voice_slot
    import synth_voice_pkg::*;
#(
    parameter int NUM_KEYS = NUM_KEYS_DEF,
    parameter int KEY_W    = 2,
    parameter int AGE_W    = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 assign_i,
    input  logic                 age_inc_i,
    input  logic [KEY_W-1:0]     key_idx_i,
    input  logic [NUM_KEYS-1:0]  key_on_i,
    input  logic [RELEASE_W-1:0] release_len_i,
    output voice_state_t         state_o,
    output logic [AGE_W-1:0]     age_o,
    output logic [KEY_W-1:0]     key_o,
    output logic                 trig_o
);

    voice_state_t         state_q;
    logic [RELEASE_W-1:0] cnt_q;
    logic [AGE_W-1:0]     age_q;
    logic [KEY_W-1:0]     key_q;
    logic                 trig_q;

    // An assigned key was high when assigned, so its first low level is its fall.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= V_IDLE;
            cnt_q   <= '0;
            age_q   <= '0;
            key_q   <= '0;
            trig_q  <= 1'b0;
        end else begin
            trig_q <= assign_i;
            if (assign_i) begin
                state_q <= V_ACTIVE;
                key_q   <= key_idx_i;
                age_q   <= '0;
            end else begin
                if (age_inc_i && (age_q != '1))
                    age_q <= age_q + 1'b1;
                case (state_q)
                    V_ACTIVE: begin
                        if (!key_on_i[key_q]) begin
                            state_q <= V_RELEASE;
                            cnt_q   <= release_len_i;
                        end
                    end
                    V_RELEASE: begin
                        if (cnt_q == '0) state_q <= V_IDLE;
                        else             cnt_q   <= cnt_q - 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign state_o = state_q;
    assign age_o   = age_q;
    assign key_o   = key_q;
    assign trig_o  = trig_q;

endmodule

// File: rtl/voice_allocator.sv
// Key edge detection, pending queue and voice assignment onto a pool of voice_slot instances.
// Define VOICE_STEAL_EN to steal the oldest voice when no voice is IDLE.
module voice_allocator
    import synth_voice_pkg::*;
#(
    parameter int NUM_KEYS   = NUM_KEYS_DEF,
    parameter int NUM_VOICES = NUM_VOICES_DEF,
    parameter int KEY_W      = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
    parameter int AGE_W      = 4
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [NUM_KEYS-1:0]         key_on,
    input  logic [RELEASE_W-1:0]        release_len,
    output logic [NUM_VOICES-1:0]       voice_gate,
    output logic [NUM_VOICES-1:0]       voice_busy,
    output logic [NUM_VOICES-1:0]       voice_trig,
    output logic [NUM_VOICES*KEY_W-1:0] voice_key
);

    localparam int VOICE_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic [NUM_KEYS-1:0]               key_q, pending_q, pending_d;
    logic [NUM_KEYS-1:0]               rise, fall, req_vec;
    logic                              req_vld, free_vld, do_assign;
    logic [KEY_W-1:0]                  req_idx;
    logic [VOICE_W-1:0]                free_idx, tgt_idx;
    logic [NUM_VOICES-1:0]             assign_vec, age_inc;
    voice_state_t                      state [NUM_VOICES];
    logic [NUM_VOICES-1:0][AGE_W-1:0]  age;
    logic [NUM_VOICES-1:0][KEY_W-1:0]  slot_key;

    assign rise    = key_on & ~key_q;
    assign fall    = ~key_on & key_q;
    // A request whose key is falling this cycle is withdrawn, not served.
    assign req_vec = pending_q & ~fall;

`ifdef VOICE_STEAL_EN
    logic               rel_vld, act_vld;
    logic [VOICE_W-1:0] rel_idx, act_idx;
    logic [AGE_W-1:0]   rel_age, act_age;
`else
    logic unused_age;
    assign unused_age = ^age;
`endif

    always_comb begin
        req_vld  = 1'b0;
        req_idx  = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (req_vec[k]) begin
                req_vld = 1'b1;
                req_idx = KEY_W'(k);
            end
        end
        free_vld = 1'b0;
        free_idx = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (state[v] == V_IDLE) begin
                free_vld = 1'b1;
                free_idx = VOICE_W'(v);
            end
        end
`ifdef VOICE_STEAL_EN
        rel_vld = 1'b0; rel_idx = '0; rel_age = '0;
        act_vld = 1'b0; act_idx = '0; act_age = '0;
        // Strict compare keeps the lowest index among equal ages.
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (state[v] == V_RELEASE && (!rel_vld || age[v] > rel_age)) begin
                rel_vld = 1'b1;
                rel_idx = VOICE_W'(v);
                rel_age = age[v];
            end
            if (state[v] == V_ACTIVE && (!act_vld || age[v] > act_age)) begin
                act_vld = 1'b1;
                act_idx = VOICE_W'(v);
                act_age = age[v];
            end
        end
        do_assign = req_vld;
        tgt_idx   = free_vld ? free_idx : (rel_vld ? rel_idx : act_idx);
`else
        do_assign = req_vld & free_vld;
        tgt_idx   = free_idx;
`endif
        assign_vec = '0;
        age_inc    = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            assign_vec[v] = do_assign && (tgt_idx == VOICE_W'(v));
            age_inc[v]    = do_assign && !assign_vec[v] && (state[v] != V_IDLE);
        end
        pending_d = (pending_q | rise) & ~fall;
        if (do_assign) pending_d[req_idx] = 1'b0;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            key_q     <= '0;
            pending_q <= '0;
        end else begin
            key_q     <= key_on;
            pending_q <= pending_d;
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_slot
        voice_slot #(
            .NUM_KEYS (NUM_KEYS),
            .KEY_W    (KEY_W),
            .AGE_W    (AGE_W)
        ) u_slot (
            .CLK           (CLK),
            .RESET         (RESET),
            .assign_i      (assign_vec[v]),
            .age_inc_i     (age_inc[v]),
            .key_idx_i     (req_idx),
            .key_on_i      (key_on),
            .release_len_i (release_len),
            .state_o       (state[v]),
            .age_o         (age[v]),
            .key_o         (slot_key[v]),
            .trig_o        (voice_trig[v])
        );
        assign voice_gate[v]                 = (state[v] == V_ACTIVE);
        assign voice_busy[v]                 = (state[v] != V_IDLE);
        assign voice_key[v*KEY_W +: KEY_W]   = slot_key[v];
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator (4 keys, 2 voices); steal scenarios when VOICE_STEAL_EN is defined.
module tb_voice_allocator;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [3:0]  key_on = '0;
    logic [15:0] release_len = '0;
    logic [1:0]  voice_gate, voice_busy, voice_trig;
    logic [3:0]  voice_key;
    logic [3:0]  base;
    int          vectors = 0;
    int          errs = 0;

    voice_allocator #(
        .NUM_KEYS   (4),
        .NUM_VOICES (2),
        .KEY_W      (2),
        .AGE_W      (4)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .key_on      (key_on),
        .release_len (release_len),
        .voice_gate  (voice_gate),
        .voice_busy  (voice_busy),
        .voice_trig  (voice_trig),
        .voice_key   (voice_key)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] g, input logic [1:0] b,
                       input logic [1:0] t, input logic [3:0] k);
        vectors++;
        assert ({voice_gate, voice_busy, voice_trig, voice_key} === {g, b, t, k})
        else begin
            errs++;
            $error("FAIL %s: got gate=%b busy=%b trig=%b key=%b, want gate=%b busy=%b trig=%b key=%b",
                   tag, voice_gate, voice_busy, voice_trig, voice_key, g, b, t, k);
        end
    endtask

    initial begin
        tick();
        tick();
        chk("reset", 2'b00, 2'b00, 2'b00, 4'b0000);
        RESET = 1'b0;

        // Single key, release tail of 3 -> four busy cycles after the fall.
        key_on = 4'b0001; release_len = 16'd3;
        tick(); chk("t1_pending", 2'b00, 2'b00, 2'b00, 4'b0000);
        tick(); chk("t1_trig",    2'b01, 2'b01, 2'b01, 4'b0000);
        tick(); chk("t1_hold",    2'b01, 2'b01, 2'b00, 4'b0000);
        key_on = 4'b0000;
        tick(); chk("t1_rel",     2'b00, 2'b01, 2'b00, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            tick(); chk("t1_tail", 2'b00, 2'b01, 2'b00, 4'b0000);
        end
        tick(); chk("t1_idle",    2'b00, 2'b00, 2'b00, 4'b0000);

`ifndef VOICE_STEAL_EN
        // Three simultaneous presses on two voices; key2 waits for voice0.
        key_on = 4'b0111; release_len = 16'd0;
        tick(); chk("t2_pending", 2'b00, 2'b00, 2'b00, 4'b0000);
        tick(); chk("t2_key0",    2'b01, 2'b01, 2'b01, 4'b0000);
        tick(); chk("t2_key1",    2'b11, 2'b11, 2'b10, 4'b0100);
        tick(); chk("t2_wait",    2'b11, 2'b11, 2'b00, 4'b0100);
        key_on = 4'b0110;
        tick(); chk("t2_rel0",    2'b10, 2'b11, 2'b00, 4'b0100);
        tick(); chk("t2_idle0",   2'b10, 2'b10, 2'b00, 4'b0100);
        tick(); chk("t2_key2",    2'b11, 2'b11, 2'b01, 4'b0110);
        base = 4'b0110;
`else
        // Successive presses; key2 steals the oldest ACTIVE voice (voice0).
        key_on = 4'b0001; release_len = 16'd10;
        tick(); chk("s1_pending", 2'b00, 2'b00, 2'b00, 4'b0000);
        key_on = 4'b0011;
        tick(); chk("s1_key0",    2'b01, 2'b01, 2'b01, 4'b0000);
        key_on = 4'b0111;
        tick(); chk("s1_key1",    2'b11, 2'b11, 2'b10, 4'b0100);
        tick(); chk("s1_steal",   2'b11, 2'b11, 2'b01, 4'b0110);
        key_on = 4'b0101;
        tick(); chk("s2_rel1",    2'b01, 2'b11, 2'b00, 4'b0110);
        key_on = 4'b1101;
        tick(); chk("s2_pending", 2'b01, 2'b11, 2'b00, 4'b0110);
        tick(); chk("s2_steal1",  2'b11, 2'b11, 2'b10, 4'b1110);
        // voice1 now younger than voice0; put it in RELEASE and press again.
        key_on = 4'b0101;
        tick(); chk("s3_rel1",    2'b01, 2'b11, 2'b00, 4'b1110);
        key_on = 4'b0111;
        tick(); chk("s3_pending", 2'b01, 2'b11, 2'b00, 4'b1110);
        tick(); chk("s3_steal_rel", 2'b11, 2'b11, 2'b10, 4'b0110);
        base = 4'b0111;
`endif

        // Short press while the pool is full: withdrawn, never served.
        key_on = base | 4'b1000;
        tick(); chk("t3_press",   2'b11, 2'b11, 2'b00, 4'b0110);
        key_on = base;
        tick(); chk("t3_drop",    2'b11, 2'b11, 2'b00, 4'b0110);
        tick(); chk("t3_none",    2'b11, 2'b11, 2'b00, 4'b0110);
        key_on = 4'b0000; release_len = 16'd0;
        tick(); chk("t3_rel",     2'b00, 2'b11, 2'b00, 4'b0110);
        tick(); chk("t3_idle",    2'b00, 2'b00, 2'b00, 4'b0110);
        tick(); chk("t3_quiet",   2'b00, 2'b00, 2'b00, 4'b0110);

        // Async reset mid-RELEASE with key3 held, then key3 re-allocated.
        key_on = 4'b1001; release_len = 16'd5;
        tick(); chk("t4_pending", 2'b00, 2'b00, 2'b00, 4'b0110);
        tick(); chk("t4_key0",    2'b01, 2'b01, 2'b01, 4'b0100);
        tick(); chk("t4_key3",    2'b11, 2'b11, 2'b10, 4'b1100);
        key_on = 4'b1000;
        tick(); chk("t4_rel0",    2'b10, 2'b11, 2'b00, 4'b1100);
        tick(); chk("t4_tail",    2'b10, 2'b11, 2'b00, 4'b1100);
        #2 RESET = 1'b1;
        #1 chk("t4_async_rst", 2'b00, 2'b00, 2'b00, 4'b0000);
        tick(); chk("t4_rst_hold", 2'b00, 2'b00, 2'b00, 4'b0000);
        RESET = 1'b0;
        tick(); chk("t4_rise",    2'b00, 2'b00, 2'b00, 4'b0000);
        tick(); chk("t4_realloc", 2'b01, 2'b01, 2'b01, 4'b0011);
        tick(); chk("t4_hold",    2'b01, 2'b01, 2'b00, 4'b0011);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
